// File: rtl/dsa_bilinear_interp_simd.sv
// rtl/dsa_bilinear_interp_simd.sv - SIMD bilinear interpolation with serial per-lane write-back
module dsa_bilinear_interp_simd #(
  parameter int ADDR_WIDTH = 18,
  parameter int OUT_WIDTH  = 1024,
  parameter int SIMD_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*SIMD_WIDTH-1:0]  p00,
  input  logic [8*SIMD_WIDTH-1:0]  p01,
  input  logic [8*SIMD_WIDTH-1:0]  p10,
  input  logic [8*SIMD_WIDTH-1:0]  p11,
  input  logic [16*SIMD_WIDTH-1:0] a,
  input  logic [16*SIMD_WIDTH-1:0] b,
  input  logic [15:0]              dst_x,
  input  logic [15:0]              dst_y,
  input  logic [ADDR_WIDTH-1:0]    dst_base_addr,
  output logic                     mem_write_en,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [7:0]               mem_data,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = (SIMD_WIDTH > 1) ? $clog2(SIMD_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(SIMD_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HCALC = 3'd1,
    ST_VCALC = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]  r_p00 [SIMD_WIDTH];
  logic [7:0]  r_p01 [SIMD_WIDTH];
  logic [7:0]  r_p10 [SIMD_WIDTH];
  logic [7:0]  r_p11 [SIMD_WIDTH];
  logic [7:0]  r_a   [SIMD_WIDTH];
  logic [7:0]  r_b   [SIMD_WIDTH];
  logic [15:0] r_top [SIMD_WIDTH];
  logic [15:0] r_bot [SIMD_WIDTH];
  logic [7:0]  r_pix [SIMD_WIDTH];
  logic [15:0] w_top [SIMD_WIDTH];
  logic [15:0] w_bot [SIMD_WIDTH];
  logic [7:0]  w_pix [SIMD_WIDTH];

  logic [15:0]           r_dst_x;
  logic [15:0]           r_dst_y;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_row_base;

  logic [CW-1:0]         r_lane;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_data;
  logic                  r_done;

  logic [CW-1:0]         w_lane_next;
  logic                  w_lane_in;
  logic                  w_accept;

  // Only the low byte of each fraction word carries Q0.8 data.
  logic                  w_unused;
  assign w_unused = ^{a, b};

  assign w_accept = (r_state == ST_IDLE) && in_valid;

  // Per-lane arithmetic: horizontal blend of both rows, then vertical blend with rounding.
  for (genvar i = 0; i < SIMD_WIDTH; i++) begin : g_lane
    logic [8:0]  w_ia;
    logic [8:0]  w_ib;
    logic [23:0] w_acc;
    logic [8:0]  w_round;

    assign w_ia    = 9'd256 - {1'b0, r_a[i]};
    assign w_ib    = 9'd256 - {1'b0, r_b[i]};
    assign w_top[i] = 16'(r_p00[i]) * 16'(w_ia) + 16'(r_p01[i]) * 16'(r_a[i]);
    assign w_bot[i] = 16'(r_p10[i]) * 16'(w_ia) + 16'(r_p11[i]) * 16'(r_a[i]);
    assign w_acc   = 24'(r_top[i]) * 24'(w_ib) + 24'(r_bot[i]) * 24'(r_b[i]);
    assign w_round = 9'((25'(w_acc) + 25'd32768) >> 16);
    assign w_pix[i] = w_round[8] ? 8'hFF : w_round[7:0];
  end

  // Lane about to be presented on the write port and whether its column is inside the image.
  assign w_lane_next = (r_state == ST_VCALC) ? '0 : r_lane + CW'(1);
  assign w_lane_in   = ($unsigned(32'(r_dst_x)) + $unsigned(32'(w_lane_next)))
                       < $unsigned(32'(OUT_WIDTH));

  // Bundle capture on accept; later in_valid pulses are dropped while not idle.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < SIMD_WIDTH; i++) begin
        r_p00[i] <= p00[8*i +: 8];
        r_p01[i] <= p01[8*i +: 8];
        r_p10[i] <= p10[8*i +: 8];
        r_p11[i] <= p11[8*i +: 8];
        r_a[i]   <= a[16*i +: 8];
        r_b[i]   <= b[16*i +: 8];
      end
      r_dst_x <= dst_x;
      r_dst_y <= dst_y;
      r_base  <= dst_base_addr;
    end
  end

  // Pipeline stages: horizontal results and row base in HCALC, final pixels in VCALC.
  always_ff @(posedge clk) begin
    if (r_state == ST_HCALC) begin
      for (int i = 0; i < SIMD_WIDTH; i++) begin
        r_top[i] <= w_top[i];
        r_bot[i] <= w_bot[i];
      end
      r_row_base <= r_base + ADDR_WIDTH'(32'(r_dst_y) * 32'(OUT_WIDTH));
    end
    if (r_state == ST_VCALC) begin
      for (int i = 0; i < SIMD_WIDTH; i++) begin
        r_pix[i] <= w_pix[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_next = ST_HCALC;
      ST_HCALC: w_next = ST_VCALC;
      ST_VCALC: w_next = ST_WRITE;
      ST_WRITE: if (r_lane == LAST_LANE) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Registered write port: lane 0 is loaded as VCALC ends, each following lane one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane <= '0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_VCALC: begin
          r_lane <= '0;
          r_we   <= w_lane_in;
          r_addr <= r_row_base + ADDR_WIDTH'(r_dst_x);
          r_data <= w_pix[0];
        end
        ST_WRITE: begin
          if (r_lane == LAST_LANE) begin
            r_we   <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_lane <= w_lane_next;
            r_we   <= w_lane_in;
            r_addr <= r_addr + ADDR_WIDTH'(1);
            r_data <= r_pix[w_lane_next];
          end
        end
        default: begin
          r_we <= 1'b0;
        end
      endcase
    end
  end

  assign mem_write_en = r_we;
  assign mem_addr     = r_addr;
  assign mem_data     = r_data;
  assign done         = r_done;
  assign busy         = (r_state != ST_IDLE);
  assign in_ready     = (r_state == ST_IDLE);

endmodule

// File: tb/tb_dsa_bilinear_interp_simd.sv
// tb/tb_dsa_bilinear_interp_simd.sv - scoreboard bench for dsa_bilinear_interp_simd
module tb_dsa_bilinear_interp_simd;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] p00, p01, p10, p11;
  logic [63:0] a, b;
  logic [15:0] dst_x, dst_y;
  logic [17:0] dst_base_addr;
  logic        mem_write_en;
  logic [17:0] mem_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [17:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;

  always #5 clk = ~clk;

  dsa_bilinear_interp_simd #(
    .ADDR_WIDTH(18),
    .OUT_WIDTH (1024),
    .SIMD_WIDTH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .p00          (p00),
    .p01          (p01),
    .p10          (p10),
    .p11          (p11),
    .a            (a),
    .b            (b),
    .dst_x        (dst_x),
    .dst_y        (dst_y),
    .dst_base_addr(dst_base_addr),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .busy         (busy),
    .done         (done)
  );

  // Write-port monitor: every strobed write must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) n_done++;
    if (rst === 1'b0 && mem_write_en === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%0d data=%0d required no write", mem_addr, mem_data);
      end else begin
        e = sb.pop_front();
        if (mem_addr !== e.addr || mem_data !== e.data)
          $display("FAIL write: got addr=%0d data=%0d required addr=%0d data=%0d",
                   mem_addr, mem_data, e.addr, e.data);
        else
          n_pass++;
      end
    end
  end

  function automatic int model_pix(int q00, int q01, int q10, int q11, int fa, int fb);
    int top, bot, acc, r;
    top = q00 * (256 - fa) + q01 * fa;
    bot = q10 * (256 - fa) + q11 * fa;
    acc = top * (256 - fb) + bot * fb;
    r = (acc + 32768) / 65536;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic push_exp(input int addr, input int data);
    exp_t e;
    e.addr = 18'(addr);
    e.data = 8'(data);
    sb.push_back(e);
  endtask

  // Drives a one-cycle in_valid pulse; returns #1 into the cycle after acceptance (T+1).
  task automatic start_bundle(input logic [31:0] v00, input logic [31:0] v01,
                              input logic [31:0] v10, input logic [31:0] v11,
                              input logic [63:0] va, input logic [63:0] vb,
                              input logic [15:0] x, input logic [15:0] y,
                              input logic [17:0] base, input bit use_model);
    p00 = v00; p01 = v01; p10 = v10; p11 = v11;
    a = va; b = vb;
    dst_x = x; dst_y = y; dst_base_addr = base;
    in_valid = 1'b1;
    if (use_model) begin
      for (int k = 0; k < 4; k++) begin
        longint ad;
        ad = longint'(base) + longint'(y) * 1024 + longint'(x) + k;
        if (int'(x) + k < 1024)
          push_exp(int'(ad % 262144),
                   model_pix(int'(v00[8*k +: 8]), int'(v01[8*k +: 8]),
                             int'(v10[8*k +: 8]), int'(v11[8*k +: 8]),
                             int'(va[16*k +: 8]), int'(vb[16*k +: 8])));
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(sb.size() == 0 && in_ready === 1'b1 && busy === 1'b0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (sb.size() != 0 || in_ready !== 1'b1)
      $display("FAIL %s_drain: got pending=%0d in_ready=%b required pending=0 in_ready=1",
               name, sb.size(), in_ready);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0;
    p00 = '0; p01 = '0; p10 = '0; p11 = '0; a = '0; b = '0;
    dst_x = '0; dst_y = '0; dst_base_addr = '0;
    step(3);
    n_checks++; if (mem_write_en !== 1'b0) $display("FAIL rst_we: got %b required 0", mem_write_en); else n_pass++;
    n_checks++; if (mem_addr !== 18'd0) $display("FAIL rst_addr: got %0d required 0", mem_addr); else n_pass++;
    n_checks++; if (mem_data !== 8'd0) $display("FAIL rst_data: got %0d required 0", mem_data); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b required 0", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b required 1", in_ready); else n_pass++;
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_passthrough();
    push_exp(2056, 10); push_exp(2057, 20); push_exp(2058, 30); push_exp(2059, 40);
    start_bundle(32'h281E140A, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 64'h0, 64'h0, 16'd8, 16'd2, 18'd0, 1'b0);
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL pt_busy_t1: got ready=%b busy=%b required ready=0 busy=1", in_ready, busy); else n_pass++;
    step(2);
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (mem_write_en !== 1'b1 || mem_addr !== 18'(2056 + k))
        $display("FAIL pt_lane%0d_timing: got we=%b addr=%0d required we=1 addr=%0d", k, mem_write_en, mem_addr, 2056 + k);
      else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL pt_early_done: got %b required 0", done); else n_pass++;
      step(1);
    end
    n_checks++; if (done !== 1'b1 || mem_write_en !== 1'b0)
      $display("FAIL pt_done_t7: got done=%b we=%b required done=1 we=0", done, mem_write_en); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL pt_ready_t7: got %b required 0", in_ready); else n_pass++;
    step(1);
    n_checks++; if (in_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL pt_idle_t8: got ready=%b done=%b busy=%b required 1 0 0", in_ready, done, busy); else n_pass++;
    wait_idle("passthrough");
  endtask

  task automatic test_half();
    for (int k = 0; k < 4; k++) push_exp(3076 + k, 128);
    start_bundle(32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF,
                 64'h0080_0080_0080_0080, 64'h0, 16'd4, 16'd3, 18'd0, 1'b0);
    wait_idle("half");
  endtask

  task automatic test_corner();
    for (int k = 0; k < 4; k++) push_exp(1124 + k, 198);
    start_bundle(32'h0, 32'h0, 32'h0, 32'hC8C8C8C8,
                 64'h00FF_00FF_00FF_00FF, 64'h00FF_00FF_00FF_00FF, 16'd0, 16'd1, 18'd100, 1'b0);
    wait_idle("corner");
  endtask

  task automatic test_edge_x();
    int d0;
    push_exp(1022, 4); push_exp(1023, 3);
    d0 = n_done;
    start_bundle(32'h01020304, 32'h0, 32'h0, 32'h0, 64'h0, 64'h0, 16'd1022, 16'd0, 18'd0, 1'b0);
    step(2);
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (mem_write_en !== (k < 2) || mem_addr !== 18'(1022 + k))
        $display("FAIL edge_lane%0d: got we=%b addr=%0d required we=%0d addr=%0d", k, mem_write_en, mem_addr, (k < 2), 1022 + k);
      else n_pass++;
      step(1);
    end
    n_checks++; if (done !== 1'b1) $display("FAIL edge_done_t7: got %b required 1", done); else n_pass++;
    wait_idle("edge_x");
    n_checks++; if (n_done - d0 !== 1) $display("FAIL edge_done_count: got %0d required 1", n_done - d0); else n_pass++;
  endtask

  task automatic test_ignore_busy();
    int d0;
    d0 = n_done;
    for (int k = 0; k < 4; k++) push_exp(5 * 1024 + 16 + k, 50 + k);
    start_bundle(32'h35343332, 32'h0, 32'h0, 32'h0, 64'h0, 64'h0, 16'd16, 16'd5, 18'd0, 1'b0);
    for (int t = 1; t <= 7; t++) begin
      n_checks++; if (in_ready !== 1'b0) $display("FAIL ign_ready_t%0d: got %b required 0", t, in_ready); else n_pass++;
      if (t == 4)
        start_bundle(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD,
                     64'h0040_0040_0040_0040, 64'h0040_0040_0040_0040, 16'd0, 16'd9, 18'd7, 1'b0);
      else
        step(1);
    end
    n_checks++; if (in_ready !== 1'b1) $display("FAIL ign_ready_t8: got %b required 1", in_ready); else n_pass++;
    wait_idle("ignore");
    step(10);
    n_checks++; if (n_done - d0 !== 1) $display("FAIL ign_done_count: got %0d required 1", n_done - d0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = n_done;
    for (int k = 0; k < 4; k++) push_exp(700 + k, 90 + k);
    start_bundle(32'h5D5C5B5A, 32'h0, 32'h0, 32'h0, 64'h0, 64'h0, 16'd700, 16'd0, 18'd0, 1'b0);
    step(3);
    rst = 1'b1;
    step(1);
    n_checks++; if (mem_write_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midrst_t5: got we=%b done=%b busy=%b ready=%b required 0 0 0 1", mem_write_en, done, busy, in_ready);
    else n_pass++;
    n_checks++; if (sb.size() !== 3) $display("FAIL midrst_lane0: got pending=%0d required 3", sb.size()); else n_pass++;
    sb.delete();
    rst = 1'b0;
    step(1);
    start_bundle(32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 64'h0080_0040_00C0_0001, 64'h0,
                 16'd40, 16'd7, 18'd3, 1'b1);
    wait_idle("reset_mid");
    step(2);
    n_checks++; if (n_done - d0 !== 1) $display("FAIL midrst_done_count: got %0d required 1", n_done - d0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      logic [15:0] x;
      x = (i % 2 == 0) ? 16'($urandom_range(1018, 1023)) : 16'($urandom_range(0, 1023));
      start_bundle($urandom, $urandom, $urandom, $urandom,
                   {$urandom, $urandom}, {$urandom, $urandom},
                   x, 16'($urandom_range(0, 400)), 18'($urandom), 1'b1);
      step(7);
      n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b required 1", i, in_ready); else n_pass++;
    end
    wait_idle("back_to_back");
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_half();
    test_corner();
    test_edge_x();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dsa_bilinear_interp_simd.md
Name: dsa_bilinear_interp_simd

Overview:
Downstream consumer of the SIMD pixel-fetch stage. It accepts one fetch bundle per request: four neighbours and Q0.8 fractions for each of SIMD_WIDTH lanes. It computes the rounded bilinear interpolation per lane in a short pipeline, then writes the SIMD_WIDTH result pixels serially to the destination image memory. One instance per SIMD fetch unit, between fetch and the output frame buffer.

Parameters:
ADDR_WIDTH, 18, destination memory address width
OUT_WIDTH, 1024, destination image width in pixels (row stride)
SIMD_WIDTH, 4, lanes per bundle; 4 is the only value verified

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  bundle valid; 1-cycle pulse, driven by fetch_valid
in_ready  out  1  high only in ST_IDLE
p00/p01/p10/p11  in  8 x SIMD_WIDTH  neighbours: top-left, top-right, bottom-left, bottom-right
a  in  16 x SIMD_WIDTH  x fraction; only [7:0] used (Q0.8)
b  in  16 x SIMD_WIDTH  y fraction; only [7:0] used (Q0.8)
dst_x  in  16  destination x of lane 0; lane i is dst_x+i
dst_y  in  16  destination row
dst_base_addr  in  ADDR_WIDTH  destination image base
mem_write_en  out  1  write strobe
mem_addr  out  ADDR_WIDTH  write address
mem_data  out  8  write data
busy  out  1  high whenever state != ST_IDLE
done  out  1  1-cycle pulse when a bundle is fully retired

Behaviour:
- Reset (synchronous): state=ST_IDLE; lane counter=0; mem_write_en=0, mem_addr=0, mem_data=0, done=0, busy=0; in_ready=1.
- States: ST_IDLE -> ST_HCALC -> ST_VCALC -> ST_WRITE (SIMD_WIDTH cycles) -> ST_DONE -> ST_IDLE.
- Accept: in cycle T, state is ST_IDLE and in_valid=1. All lane inputs plus dst_x, dst_y and dst_base_addr are registered at T. in_valid while not ST_IDLE is ignored: no capture, no error.
- ST_HCALC (T+1), per lane:
  - top = p00*(256-a) + p01*a, 16-bit unsigned.
  - bot = p10*(256-a) + p11*a, 16-bit unsigned.
  - Both results are registered.
- ST_VCALC (T+2), per lane:
  - acc = top*(256-b) + bot*b, 24-bit unsigned.
  - pix = (acc + 32768) >> 16, clamped to 255.
  - pix is registered.
- Row base: row_base = dst_base_addr + dst_y*OUT_WIDTH, computed during ST_HCALC/ST_VCALC. Address arithmetic wraps modulo 2^ADDR_WIDTH.
- ST_WRITE (T+3 .. T+2+SIMD_WIDTH): lane k is presented in cycle T+3+k.
  - mem_addr = row_base + dst_x + k; mem_data = pix[k].
  - mem_write_en = 1 only if dst_x+k < OUT_WIDTH, else 0. The cycle is still consumed, so timing never varies.
  - Address, data and strobe are valid in the same cycle.
  - Outputs are registered from state/counter; there is no combinational path from inputs.
- Lane counter advances by 1 per ST_WRITE cycle. Exit to ST_DONE when counter == SIMD_WIDTH-1.
- ST_DONE (T+3+SIMD_WIDTH = T+7):
  - done=1, mem_write_en=0.
  - Next cycle returns to ST_IDLE with in_ready=1.
  - A new bundle is acceptable at T+8 at the earliest.
- Latency: accept to first write is 3 cycles. Throughput is one bundle per 8 cycles (SIMD_WIDTH=4).
- Fraction edge cases: a=0 or b=0 selects the left/top neighbour exactly. a=255 weights the right neighbour 255/256. No special-casing.
- mem_write_en deasserts outside ST_WRITE. mem_addr/mem_data hold their last value.
- Reset mid-operation: the next cycle is ST_IDLE with all outputs at reset values. No further writes are issued, and done does not fire for the aborted bundle.

Test Plan:
1. a=b=0, p00={10,20,30,40}, dst_base=0, dst_y=2, dst_x=8, in_valid at T -> writes (2056,10),(2057,20),(2058,30),(2059,40) in T+3..T+6; done=1 at T+7; in_ready=1 at T+8.
2. All lanes: p00=p10=0, p01=p11=255, a=128, b=0 -> every mem_data=128.
3. All lanes: p00=p01=p10=0, p11=200, a=b=255 -> mem_data=198 (acc=13005000).
4. OUT_WIDTH=1024, dst_x=1022, dst_y=0, base=0 -> mem_write_en=1 at T+3 (addr 1022) and T+4 (addr 1023), 0 at T+5 and T+6; done still at T+7.
5. Second in_valid pulse at T+4 with different data -> ignored. in_ready=0 during T+1..T+7, and only the first bundle is written.
6. rst asserted at T+4 (after lane 0 is written) -> from T+5: mem_write_en=0, done=0, busy=0, in_ready=1; lanes 1..3 are never written. A new bundle at T+6 completes normally.
